// File: rtl/imc_macro_sequencer.sv
// rtl/imc_macro_sequencer.sv - command sequencer for the 16x16 in-memory-compute SRAM macro
// Times precharge / word-line / sense phases and returns READ or MAC results over valid/ready.
module imc_macro_sequencer #(
    parameter int T_PRE = 2,
    parameter int T_WL  = 2,
    parameter int T_SA  = 1,
    parameter int T_ADC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_row,
    input  logic [15:0] cmd_data,
    input  logic [15:0] cmd_datab,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_op,
    output logic [15:0] rsp_data,
    output logic [63:0] rsp_mac,
    output logic        rsp_err,
    output logic [15:0] wwl,
    output logic [7:0]  wwld,
    output logic [15:0] rwl,
    output logic [15:0] rwlb,
    output logic [15:0] din,
    output logic        we,
    output logic        pre_sram,
    output logic        pre_vlsa,
    output logic        pre_clsa,
    output logic        pre_a,
    output logic        saen,
    output logic        en,
    input  logic [15:0] sa_out,
    input  logic [63:0] adc_out
);

    typedef enum logic [2:0] {IDLE, PRE, WL, SENSE, RESP} state_t;

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_MAC    = 2'd2;
    localparam logic [1:0] OP_DWRITE = 2'd3;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;
    logic [1:0]  op_q, op_sel;
    logic [3:0]  row_q;
    logic [15:0] data_q, datab_q;

    logic [15:0] wwl_n, rwl_n, rwlb_n, din_n;
    logic [7:0]  wwld_n;
    logic        we_n, pre_sram_n, pre_vlsa_n, pre_clsa_n, pre_a_n, saen_n, en_n;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = PRE;
                    cnt_next   = 4'(T_PRE);
                end
            end
            PRE: begin
                if (cnt == 4'd1) begin
                    state_next = WL;
                    cnt_next   = 4'(T_WL);
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            WL: begin
                if (cnt == 4'd1) begin
                    if (op_q == OP_WRITE || op_q == OP_DWRITE) begin
                        state_next = RESP;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = SENSE;
                        cnt_next   = (op_q == OP_READ) ? 4'(T_SA) : 4'(T_ADC);
                    end
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            SENSE: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Macro pins are decoded from the state being entered so they can be registered.
    always_comb begin
        op_sel     = accept ? cmd_op : op_q;
        wwl_n      = 16'h0000;
        wwld_n     = 8'h00;
        rwl_n      = 16'h0000;
        rwlb_n     = 16'h0000;
        din_n      = 16'h0000;
        we_n       = 1'b0;
        pre_sram_n = 1'b0;
        pre_vlsa_n = 1'b0;
        pre_clsa_n = 1'b0;
        pre_a_n    = 1'b0;
        saen_n     = 1'b0;
        en_n       = 1'b0;
        case (state_next)
            PRE: begin
                pre_sram_n = 1'b1;
                pre_vlsa_n = (op_sel == OP_READ);
                pre_clsa_n = (op_sel == OP_MAC);
                pre_a_n    = (op_sel == OP_MAC);
            end
            WL, SENSE: begin
                case (op_q)
                    OP_WRITE: begin
                        wwl_n = 16'h0001 << row_q;
                        din_n = data_q;
                        we_n  = 1'b1;
                    end
                    OP_DWRITE: begin
                        wwld_n = 8'h01 << row_q[2:0];
                        din_n  = data_q;
                        we_n   = 1'b1;
                    end
                    OP_READ: begin
                        rwl_n  = 16'h0001 << row_q;
                        saen_n = (state_next == SENSE);
                    end
                    default: begin
                        // Bits set in both vectors are cancelled on both lines.
                        rwl_n  = data_q & ~datab_q;
                        rwlb_n = datab_q & ~data_q;
                        en_n   = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_op    <= 2'd0;
            rsp_data  <= 16'h0000;
            rsp_mac   <= 64'h0;
            rsp_err   <= 1'b0;
            op_q      <= 2'd0;
            row_q     <= 4'd0;
            data_q    <= 16'h0000;
            datab_q   <= 16'h0000;
            wwl       <= 16'h0000;
            wwld      <= 8'h00;
            rwl       <= 16'h0000;
            rwlb      <= 16'h0000;
            din       <= 16'h0000;
            we        <= 1'b0;
            pre_sram  <= 1'b0;
            pre_vlsa  <= 1'b0;
            pre_clsa  <= 1'b0;
            pre_a     <= 1'b0;
            saen      <= 1'b0;
            en        <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cmd_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == RESP);
            wwl       <= wwl_n;
            wwld      <= wwld_n;
            rwl       <= rwl_n;
            rwlb      <= rwlb_n;
            din       <= din_n;
            we        <= we_n;
            pre_sram  <= pre_sram_n;
            pre_vlsa  <= pre_vlsa_n;
            pre_clsa  <= pre_clsa_n;
            pre_a     <= pre_a_n;
            saen      <= saen_n;
            en        <= en_n;
            if (accept) begin
                op_q    <= cmd_op;
                row_q   <= cmd_row;
                data_q  <= cmd_data;
                datab_q <= cmd_datab;
            end
            if (state_next == RESP && state != RESP) begin
                rsp_op   <= op_q;
                rsp_data <= (op_q == OP_READ) ? sa_out : 16'h0000;
                rsp_mac  <= (op_q == OP_MAC) ? adc_out : 64'h0;
                rsp_err  <= (op_q == OP_MAC) && |(data_q & datab_q);
            end
        end
    end

endmodule

// File: tb/tb_imc_macro_sequencer.sv
// tb/tb_imc_macro_sequencer.sv - scoreboard bench for imc_macro_sequencer
module tb_imc_macro_sequencer;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, we;
    logic [1:0]  cmd_op, rsp_op;
    logic [3:0]  cmd_row;
    logic [15:0] cmd_data, cmd_datab, rsp_data, wwl, rwl, rwlb, din, sa_out;
    logic [7:0]  wwld;
    logic [63:0] rsp_mac, adc_out;
    logic        pre_sram, pre_vlsa, pre_clsa, pre_a, saen, en;

    imc_macro_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_row(cmd_row),
        .cmd_data(cmd_data), .cmd_datab(cmd_datab),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
        .rsp_mac(rsp_mac), .rsp_err(rsp_err),
        .wwl(wwl), .wwld(wwld), .rwl(rwl), .rwlb(rwlb), .din(din), .we(we),
        .pre_sram(pre_sram), .pre_vlsa(pre_vlsa), .pre_clsa(pre_clsa), .pre_a(pre_a),
        .saen(saen), .en(en), .sa_out(sa_out), .adc_out(adc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] data;
        logic [63:0] mac;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [78:0]  macro_out;
    logic [163:0] all_out;
    assign macro_out = {wwl, wwld, rwl, rwlb, din, we, pre_sram, pre_vlsa, pre_clsa, pre_a, saen, en};
    assign all_out   = {cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, macro_out};

    function automatic logic [78:0] mk(input logic [15:0] w, input logic [7:0] wd,
                                       input logic [15:0] r, input logic [15:0] rb,
                                       input logic [15:0] d, input logic [6:0] ctl);
        return {w, wd, r, rb, d, ctl};
    endfunction
    // ctl = {we, pre_sram, pre_vlsa, pre_clsa, pre_a, saen, en}

    task automatic issue(input logic [1:0] op, input logic [3:0] row,
                         input logic [15:0] d, input logic [15:0] db);
        cmd_op = op; cmd_row = row; cmd_data = d; cmd_datab = db; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row = 4'd0;
        cmd_data = 16'h0; cmd_datab = 16'h0; rsp_ready = 1'b1; sa_out = 16'h0; adc_out = 64'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_out !== {1'b1, 163'b0}) begin
            errors++; $display("FAIL reset_hold got=%h want=%h", all_out, {1'b1, 163'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== {1'b1, 163'b0}) begin
            errors++; $display("FAIL reset_release got=%h want=%h", all_out, {1'b1, 163'b0});
        end
    endtask

    task automatic test_write;
        rsp_t e;
        logic [78:0] x;
        sb.push_back('{op: 2'd0, data: 16'h0, mac: 64'h0, err: 1'b0});
        issue(2'd0, 4'd5, 16'hA5A5, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            x = (c <= 2) ? mk(0, 0, 0, 0, 0, 7'b0100000) : mk(16'h0020, 0, 0, 0, 16'hA5A5, 7'b1000000);
            checks++;
            if (macro_out !== x || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL write_c%0d got=%h rv=%b cr=%b want=%h rv=0 cr=0", c, macro_out, rsp_valid, cmd_ready, x);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, macro_out} !== {1'b1, e, 79'b0}) begin
            errors++; $display("FAIL write_rsp got=%b_%h_%h_%h_%b want=1_%h_%h_%h_%b", rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, e.op, e.data, e.mac, e.err);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL write_idle cr=%b rv=%b want cr=1 rv=0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_read;
        rsp_t e;
        logic [78:0] x;
        sa_out = 16'h1234;
        sb.push_back('{op: 2'd1, data: 16'h1234, mac: 64'h0, err: 1'b0});
        issue(2'd1, 4'd3, 16'h0, 16'h0);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 2)      x = mk(0, 0, 0, 0, 0, 7'b0110000);
            else if (c <= 4) x = mk(0, 0, 16'h0008, 0, 0, 7'b0000000);
            else             x = mk(0, 0, 16'h0008, 0, 0, 7'b0000010);
            checks++;
            if (macro_out !== x || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL read_c%0d got=%h rv=%b want=%h rv=0", c, macro_out, rsp_valid, x);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, macro_out} !== {1'b1, e, 79'b0}) begin
            errors++; $display("FAIL read_rsp got=%b_%h_%h_%h_%b want=1_%h_%h_%h_%b", rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, e.op, e.data, e.mac, e.err);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL read_idle cr=%b rv=%b want cr=1 rv=0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_mac(input logic [15:0] d, input logic [15:0] db, input logic [63:0] adc,
                            input logic [15:0] want_rwl, input logic [15:0] want_rwlb, input logic want_err);
        rsp_t e;
        logic [78:0] x;
        adc_out = adc;
        sb.push_back('{op: 2'd2, data: 16'h0, mac: adc, err: want_err});
        issue(2'd2, 4'd0, d, db);
        for (int c = 1; c <= 7; c++) begin
            x = (c <= 2) ? mk(0, 0, 0, 0, 0, 7'b0101100) : mk(0, 0, want_rwl, want_rwlb, 0, 7'b0000001);
            checks++;
            if (macro_out !== x || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL mac_%h_c%0d got=%h rv=%b want=%h rv=0", d, c, macro_out, rsp_valid, x);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, macro_out} !== {1'b1, e, 79'b0}) begin
            errors++; $display("FAIL mac_%h_rsp got=%b_%h_%h_%h_%b want=1_%h_%h_%h_%b", d, rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, e.op, e.data, e.mac, e.err);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mac_%h_idle cr=%b rv=%b want cr=1 rv=0", d, cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        rsp_t e;
        int n;
        rsp_ready = 1'b0;
        sa_out = 16'hBEEF;
        sb.push_back('{op: 2'd1, data: 16'hBEEF, mac: 64'h0, err: 1'b0});
        issue(2'd1, 4'd7, 16'h0, 16'h0);
        repeat (5) @(negedge clk);
        sa_out = 16'h0000;
        sb.push_back('{op: 2'd0, data: 16'h0, mac: 64'h0, err: 1'b0});
        cmd_op = 2'd0; cmd_row = 4'd1; cmd_data = 16'h0F0F; cmd_datab = 16'h0; cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({rsp_valid, rsp_op, rsp_data, cmd_ready, pre_sram} !== {1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_hold_%0d rv=%b op=%h data=%h cr=%b pre=%b want 1 1 beef 0 0", c, rsp_valid, rsp_op, rsp_data, cmd_ready, pre_sram);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err} !== {1'b1, e}) begin
            errors++; $display("FAIL bp_rsp got=%b_%h_%h_%h_%b want=1_%h_%h_%h_%b", rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, e.op, e.data, e.mac, e.err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready, rsp_data} !== {1'b0, 1'b1, 16'hBEEF}) begin
            errors++; $display("FAIL bp_handshake rv=%b cr=%b data=%h want 0 1 beef", rsp_valid, cmd_ready, rsp_data);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, pre_sram} !== 2'b01) begin
            errors++; $display("FAIL bp_second_accept cr=%b pre=%b want 0 1", cmd_ready, pre_sram);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || n != 4) begin
            errors++; $display("FAIL bp_second_latency rv=%b cycles=%0d want rv=1 cycles=4", rsp_valid, n);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_op, rsp_data, rsp_mac, rsp_err} !== e) begin
            errors++; $display("FAIL bp_second_rsp got=%h_%h_%h_%b want=%h_%h_%h_%b", rsp_op, rsp_data, rsp_mac, rsp_err, e.op, e.data, e.mac, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_midop_reset_and_dummy;
        rsp_t e;
        logic [78:0] x;
        issue(2'd0, 4'd9, 16'h5A5A, 16'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (macro_out !== mk(16'h0200, 0, 0, 0, 16'h5A5A, 7'b1000000)) begin
            errors++; $display("FAIL rst_wl_before got=%h want=%h", macro_out, mk(16'h0200, 0, 0, 0, 16'h5A5A, 7'b1000000));
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== {1'b1, 163'b0}) begin
            errors++; $display("FAIL rst_async got=%h want=%h", all_out, {1'b1, 163'b0});
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || macro_out !== 79'b0) begin
                errors++; $display("FAIL rst_after_%0d rv=%b cr=%b macro=%h want 0 1 0", c, rsp_valid, cmd_ready, macro_out);
            end
            @(negedge clk);
        end
        sb.push_back('{op: 2'd3, data: 16'h0, mac: 64'h0, err: 1'b0});
        issue(2'd3, 4'hF, 16'h3C3C, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            x = (c <= 2) ? mk(0, 0, 0, 0, 0, 7'b0100000) : mk(0, 8'h80, 0, 0, 16'h3C3C, 7'b1000000);
            checks++;
            if (macro_out !== x || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL dwrite_c%0d got=%h rv=%b want=%h rv=0", c, macro_out, rsp_valid, x);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, macro_out} !== {1'b1, e, 79'b0}) begin
            errors++; $display("FAIL dwrite_rsp got=%b_%h_%h_%h_%b want=1_%h_%h_%h_%b", rsp_valid, rsp_op, rsp_data, rsp_mac, rsp_err, e.op, e.data, e.mac, e.err);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL dwrite_idle cr=%b rv=%b want cr=1 rv=0", cmd_ready, rsp_valid);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_mac(16'h00FF, 16'h0F00, 64'h0123456789ABCDEF, 16'h00FF, 16'h0F00, 1'b0);
        test_mac(16'h0003, 16'h0006, 64'hFEDCBA9876543210, 16'h0001, 16'h0004, 1'b1);
        test_backpressure;
        test_midop_reset_and_dummy;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
